pipe_hazard_scoreboard: RTL and testbench
=========================================

Name: pipe_hazard_scoreboard

Overview:
Parametrised hazard-detection and forwarding controller for the in-order MIPS pipeline. It replaces the fixed EXE/MEM/WB hazard and forwarding pair. It tracks every in-flight destination register across DEPTH post-decode stages and decides, at decode time, whether the instruction in ID must stall. It also registers per-source forwarding selects that are valid when that instruction reaches EXE. Depth, source count and load-ready stage are generics, and a downstream hold is supported.

Parameters:
ADDR_LEN, 5, register-file address width
DEPTH, 3, tracked stages after ID (index 0 = EXE ... DEPTH-1 = WB); min 2
NUM_SRC, 3, source operands per instruction (src1, src2, store/branch source)
LD_STAGE, 1, stage index at whose end load data becomes forwardable; 1..DEPTH-1
SEL_W, $clog2(DEPTH), width of one forwarding select

Ports:
clk  in  1  clock
rst  in  1  reset
forward_EN  in  1  runtime forwarding enable
hold  in  1  downstream freeze (e.g. memory wait)
id_valid  in  1  ID holds a live instruction (0 after flush)
id_wb_en  in  1  ID instruction writes a register
id_is_load  in  1  ID instruction is a load
id_dest  in  ADDR_LEN  ID destination register
id_src  in  NUM_SRC*ADDR_LEN  ID source registers, source s at [s*ADDR_LEN +: ADDR_LEN]
id_src_used  in  NUM_SRC  per-source "operand actually read"
stall  out  1  freeze PC and IF/ID; insert bubble into ID/EXE
exe_fwd_sel  out  NUM_SRC*SEL_W  registered select per source for the instruction now in EXE
stage_valid  out  DEPTH  live-entry flag per tracked stage

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-low.
- Reset (rst=0 at posedge): all entries are invalid, stage_valid=0, and exe_fwd_sel=0. With no hold and no valid entries, stall evaluates to 0.
- Entry per stage: valid, dest, is_load. Ready stage r = is_load ? LD_STAGE : 0.
- A source s is a candidate when id_valid, id_src_used[s] and id_src[s]!=0 all hold.
- Match: a stage k in 0..DEPTH-2 with valid, wb_en and dest==id_src[s]. The youngest match (lowest k) wins. Stage DEPTH-1 is never matched; the register file provides same-cycle write-through.
- forward_EN=1:
  - hazard_s = match at k with r > k.
  - next sel_s = k+1 on a match, else 0.
- forward_EN=0:
  - hazard_s = any match.
  - next sel_s = 0.
- stall = hold | OR(hazard_s), computed combinationally from current entries and ID inputs.
- Each posedge, when hold=0:
  - stage[k] <= stage[k-1] for k >= 1.
  - If stall=0: stage[0] <= ID instruction, with valid = id_valid & id_wb_en. Non-writing instructions enter as invalid entries.
  - If stall=1: stage[0] <= bubble.
  - exe_fwd_sel <= stall ? 0 : next sel.
- hold=1: all entries and exe_fwd_sel are frozen, and stall=1. Hold has priority over hazard.
- id_valid=0 never causes a stall. A bubble enters stage 0.
- An ID instruction whose dest equals its own source does not match itself, because it is not yet tracked.
- Reset asserted mid-operation discards all entries on that edge, regardless of hold.
- Latency: the stall decision is combinational in the same cycle. exe_fwd_sel appears one cycle after the instruction leaves ID.

Optional Feature:
- Macro SCOREBOARD_STATS_EN.
- Defined: adds outputs stall_cnt (32) and hold_cnt (32).
  - hold_cnt increments on every cycle with hold=1.
  - stall_cnt increments on cycles with a hazard stall and hold=0.
  - Both counters are cleared by reset and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Hold rst=0 for 2 cycles with random inputs, then release → stage_valid=000, stall=0, exe_fwd_sel=0.
- Issue add r3, then the next instruction reads src0=r3 with forward_EN=1 → stall=0; the following cycle exe_fwd_sel[src0]=1.
- Issue lw r4, then the next instruction reads src1=r4 → stall=1 for exactly 1 cycle and stage_valid[0]=0 (bubble); then issue with exe_fwd_sel[src1]=2.
- forward_EN=0: add r3, then use r3 → stall=1 for 2 cycles; the consumer then issues with exe_fwd_sel=0.
- Issue add r5, add r5, then use r5 → no stall, exe_fwd_sel=1 (youngest wins, not 2).
- Issue a write to r0, then read r0 → no stall. Then assert hold for 3 cycles with 2 live entries → stall=1, and stage_valid/exe_fwd_sel stay unchanged until hold drops.

Source files
------------

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard detection and forwarding-select generation for the in-order pipeline.
// Optional stall/hold counters are enabled with `define SCOREBOARD_STATS_EN.
module pipe_hazard_scoreboard #(
  parameter int ADDR_LEN = 5,
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 3,
  parameter int LD_STAGE = 1,
  parameter int SEL_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      forward_EN,
  input  logic                      hold,
  input  logic                      id_valid,
  input  logic                      id_wb_en,
  input  logic                      id_is_load,
  input  logic [ADDR_LEN-1:0]       id_dest,
  input  logic [NUM_SRC*ADDR_LEN-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  exe_fwd_sel,
  output logic [DEPTH-1:0]          stage_valid
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               hold_cnt
`endif
);

  // The oldest stage (WB) is covered by register-file write-through, so only
  // the younger DEPTH-1 stages keep a destination and load flag.
  localparam int MD = DEPTH - 1;

  logic [DEPTH-1:0]         ent_valid;
  logic [ADDR_LEN-1:0]      ent_dest [MD];
  logic [MD-1:0]            ent_load;
  logic [NUM_SRC-1:0]       hazard;
  logic [NUM_SRC*SEL_W-1:0] next_sel;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [ADDR_LEN-1:0] addr;
    logic                cand;
    logic                hit;
    logic                late;
    logic [SEL_W-1:0]    sel;

    assign addr = id_src[s*ADDR_LEN +: ADDR_LEN];
    assign cand = id_valid & id_src_used[s] & (addr != '0);

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
      hit  = 1'b0;
      late = 1'b0;
      sel  = '0;
      for (int k = MD - 1; k >= 0; k--) begin
        if (ent_valid[k] && (ent_dest[k] == addr)) begin
          hit  = 1'b1;
          late = ent_load[k] && (LD_STAGE > k);
          sel  = SEL_W'(k + 1);
        end
      end
    end

    assign hazard[s] = cand & hit & (forward_EN ? late : 1'b1);
    assign next_sel[s*SEL_W +: SEL_W] = (cand & hit & forward_EN) ? sel : '0;
  end

  assign stall       = hold | (|hazard);
  assign exe_fwd_sel = fwd_sel_q;
  assign stage_valid = ent_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid <= '0;
      ent_load  <= '0;
      fwd_sel_q <= '0;
      for (int k = 0; k < MD; k++) begin
        ent_dest[k] <= '0;
      end
    end else if (!hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
      end
      for (int k = 1; k < MD; k++) begin
        ent_dest[k] <= ent_dest[k-1];
        ent_load[k] <= ent_load[k-1];
      end
      if (stall) begin
        ent_valid[0] <= 1'b0;
        ent_dest[0]  <= '0;
        ent_load[0]  <= 1'b0;
        fwd_sel_q    <= '0;
      end else begin
        ent_valid[0] <= id_valid & id_wb_en;
        ent_dest[0]  <= id_dest;
        ent_load[0]  <= id_is_load;
        fwd_sel_q    <= next_sel;
      end
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      if (hold && (hold_cnt != '1)) begin
        hold_cnt <= hold_cnt + 32'd1;
      end
      if (!hold && (|hazard) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard with default parameters
// (DEPTH=3, NUM_SRC=3, LD_STAGE=1, SEL_W=2).
module tb_pipe_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        forward_EN = 1'b1;
  logic        hold = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_wb_en = 1'b0;
  logic        id_is_load = 1'b0;
  logic [4:0]  id_dest = '0;
  logic [14:0] id_src = '0;
  logic [2:0]  id_src_used = '0;
  logic        stall;
  logic [5:0]  exe_fwd_sel;
  logic [2:0]  stage_valid;

  int n_checks = 0;
  int n_err    = 0;

  pipe_hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .forward_EN  (forward_EN),
    .hold        (hold),
    .id_valid    (id_valid),
    .id_wb_en    (id_wb_en),
    .id_is_load  (id_is_load),
    .id_dest     (id_dest),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .stall       (stall),
    .exe_fwd_sel (exe_fwd_sel),
    .stage_valid (stage_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    check(tag, 32'(stall), 32'(exp));
  endtask

  task automatic chk_regs(input string tag, input logic [2:0] sv, input logic [5:0] fs);
    check({tag, "_sv"}, 32'(stage_valid), 32'(sv));
    check({tag, "_sel"}, 32'(exe_fwd_sel), 32'(fs));
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_wb_en    = 1'b0;
    id_is_load  = 1'b0;
    id_dest     = '0;
    id_src      = '0;
    id_src_used = '0;
  endtask

  task automatic issue(input logic wb, input logic ld, input logic [4:0] dest,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] used);
    id_valid    = 1'b1;
    id_wb_en    = wb;
    id_is_load  = ld;
    id_dest     = dest;
    id_src      = {s2, s1, s0};
    id_src_used = used;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with random ID activity
    rst = 1'b0;
    repeat (2) begin
      id_valid    = 1'($urandom);
      id_wb_en    = 1'($urandom);
      id_is_load  = 1'($urandom);
      id_dest     = 5'($urandom);
      id_src      = 15'($urandom);
      id_src_used = 3'($urandom);
      tick();
    end
    rst = 1'b1;
    idle();
    chk_regs("reset", 3'b000, 6'd0);
    chk_stall("reset_stall", 1'b0);

    // ALU producer then consumer: forward from EXE/MEM
    issue(1, 0, 5'd3, 0, 0, 0, 3'b000);
    chk_stall("t1_prod", 1'b0);
    tick();
    check("t1_sv0", 32'(stage_valid), 32'd1);
    issue(0, 0, 5'd0, 5'd3, 0, 0, 3'b001);
    chk_stall("t1_cons", 1'b0);
    tick();
    chk_regs("t1_issue", 3'b010, 6'b000001);
    drain();

    // load-use: one bubble then forward from stage 1
    issue(1, 1, 5'd4, 0, 0, 0, 3'b000);
    tick();
    issue(0, 0, 5'd0, 0, 5'd4, 0, 3'b010);
    chk_stall("t2_ld_use", 1'b1);
    tick();
    chk_regs("t2_bubble", 3'b010, 6'd0);
    chk_stall("t2_release", 1'b0);
    tick();
    chk_regs("t2_issue", 3'b100, 6'b001000);
    drain();

    // forwarding disabled: stall until producer reaches WB
    forward_EN = 1'b0;
    issue(1, 0, 5'd3, 0, 0, 0, 3'b000);
    tick();
    issue(0, 0, 5'd0, 5'd3, 0, 0, 3'b001);
    chk_stall("t3_stall1", 1'b1);
    tick();
    check("t3_sv1", 32'(stage_valid), 32'b010);
    chk_stall("t3_stall2", 1'b1);
    tick();
    check("t3_sv2", 32'(stage_valid), 32'b100);
    chk_stall("t3_go", 1'b0);
    tick();
    chk_regs("t3_issue", 3'b000, 6'd0);
    forward_EN = 1'b1;
    drain();

    // two writers of r5: youngest wins
    issue(1, 0, 5'd5, 0, 0, 0, 3'b000);
    tick();
    issue(1, 0, 5'd5, 0, 0, 0, 3'b000);
    tick();
    issue(0, 0, 5'd0, 0, 0, 5'd5, 3'b100);
    chk_stall("t4_cons", 1'b0);
    tick();
    check("t4_sel", 32'(exe_fwd_sel), 32'b010000);
    drain();

    // ALU producer two ahead: select 2
    issue(1, 0, 5'd10, 0, 0, 0, 3'b000);
    tick();
    idle();
    tick();
    issue(0, 0, 5'd0, 0, 5'd10, 0, 3'b010);
    chk_stall("t5_cons", 1'b0);
    tick();
    check("t5_sel", 32'(exe_fwd_sel), 32'b001000);
    drain();

    // load in WB stage is never matched
    issue(1, 1, 5'd11, 0, 0, 0, 3'b000);
    tick();
    idle();
    tick();
    tick();
    issue(0, 0, 5'd0, 5'd11, 0, 0, 3'b001);
    chk_stall("t6_wb_load", 1'b0);
    tick();
    check("t6_sel", 32'(exe_fwd_sel), 32'd0);
    drain();

    // unused sources and invalid ID never stall
    issue(1, 1, 5'd6, 0, 0, 0, 3'b000);
    tick();
    issue(0, 0, 5'd0, 5'd6, 5'd6, 5'd6, 3'b000);
    chk_stall("t7_unused", 1'b0);
    issue(0, 0, 5'd0, 5'd6, 5'd6, 5'd6, 3'b111);
    id_valid = 1'b0;
    chk_stall("t7_invalid", 1'b0);
    issue(0, 0, 5'd0, 5'd0, 5'd0, 5'd6, 3'b100);
    chk_stall("t7_src2_load", 1'b1);
    drain();

    // self-dependence with empty scoreboard
    issue(1, 0, 5'd12, 5'd12, 0, 0, 3'b001);
    chk_stall("t8_self", 1'b0);
    tick();
    chk_regs("t8_issue", 3'b001, 6'd0);
    drain();

    // r0 load then r0 read: no hazard
    issue(1, 1, 5'd0, 0, 0, 0, 3'b000);
    tick();
    check("t9_sv", 32'(stage_valid), 32'b001);
    issue(0, 0, 5'd0, 5'd0, 0, 0, 3'b001);
    chk_stall("t9_r0", 1'b0);
    tick();
    check("t9_sel", 32'(exe_fwd_sel), 32'd0);
    drain();

    // hold freezes two live entries and a nonzero select
    issue(1, 0, 5'd7, 0, 0, 0, 3'b000);
    tick();
    issue(1, 0, 5'd8, 5'd7, 0, 0, 3'b001);
    chk_stall("t10_cons", 1'b0);
    tick();
    chk_regs("t10_pre", 3'b011, 6'b000001);
    idle();
    hold = 1'b1;
    chk_stall("t10_hold", 1'b1);
    repeat (3) begin
      tick();
      chk_regs("t10_frozen", 3'b011, 6'b000001);
      chk_stall("t10_hold_cyc", 1'b1);
    end
    hold = 1'b0;
    chk_stall("t10_unhold", 1'b0);
    tick();
    chk_regs("t10_post", 3'b110, 6'd0);

    // reset during hold clears everything
    issue(1, 0, 5'd13, 0, 0, 0, 3'b000);
    tick();
    issue(1, 0, 5'd14, 5'd13, 0, 0, 3'b001);
    tick();
    chk_regs("t11_pre", 3'b011, 6'b000001);
    idle();
    hold = 1'b1;
    rst  = 1'b0;
    tick();
    chk_regs("t11_rst_hold", 3'b000, 6'd0);
    rst  = 1'b1;
    hold = 1'b0;
    chk_stall("t11_stall", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
